// File: rtl/sisd_pkg.sv
// Shared definitions for the SISD core: sequencer state encoding, word width
// and the default PC / halt constants.
package sisd_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] DFLT_RESET_PC  = 32'h0000_0000;
   localparam logic [WORD_W-1:0] DFLT_PC_STEP   = 32'd1;
   localparam logic [WORD_W-1:0] DFLT_HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } seq_state_e;

endpackage

// File: rtl/instr_sequencer_pc_unit.sv
// Program counter register: loads the jump target or steps sequentially
// (wrapping modulo 2^32) whenever the sequencer retires an instruction.
module pc_unit
   import sisd_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DFLT_RESET_PC,
   parameter logic [WORD_W-1:0] PC_STEP  = DFLT_PC_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              update,
   input  logic              jump_en,
   input  logic [WORD_W-1:0] jump_address,
   output logic [WORD_W-1:0] pc
);

   logic [WORD_W-1:0] pc_d;
   logic [WORD_W-1:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (update) begin
         pc_d = jump_en ? jump_address : (pc_q + PC_STEP);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer. One instruction
// in flight; every output is a flop or a decode of the state register.
module instr_sequencer
   import sisd_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = DFLT_RESET_PC,
   parameter logic [WORD_W-1:0] PC_STEP   = DFLT_PC_STEP,
   parameter logic [WORD_W-1:0] HALT_WORD = DFLT_HALT_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] instruction,
   input  logic              reg_write_enable,
   input  logic              mem_load,
   input  logic              mem_store,
   input  logic              jump_en,
   input  logic [WORD_W-1:0] jump_address,
   output logic              alu_en,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ready,
   output logic              rf_we,
   output logic [WORD_W-1:0] pc,
   output logic              halted
);

   seq_state_e        state_d, state_q;
   logic [WORD_W-1:0] instr_d, instr_q;
   logic              dmem_we_d, dmem_we_q;
   logic              rf_we_d, rf_we_q;
   logic              pc_update;

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      dmem_we_d = 1'b0;
      rf_we_d   = 1'b0;
      pc_update = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ready) begin
               if (imem_rdata == HALT_WORD) begin
                  state_d = ST_HALT;
               end else begin
                  instr_d = imem_rdata;
                  state_d = ST_DECODE;
               end
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            // Direction and write strobe are captured on entry so they stay
            // stable for the whole MEM/WB window without an input-to-output path.
            if (mem_load || mem_store) begin
               state_d   = ST_MEM;
               dmem_we_d = mem_store & ~mem_load;
            end else begin
               state_d = ST_WB;
               rf_we_d = reg_write_enable;
            end
         end
         ST_MEM: begin
            if (dmem_ready) begin
               state_d = ST_WB;
               rf_we_d = reg_write_enable;
            end else begin
               dmem_we_d = dmem_we_q;
            end
         end
         ST_WB: begin
            pc_update = 1'b1;
            state_d   = run ? ST_FETCH : ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         dmem_we_q <= 1'b0;
         rf_we_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         dmem_we_q <= dmem_we_d;
         rf_we_q   <= rf_we_d;
      end
   end

   pc_unit #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_unit (
      .clk          (clk),
      .rst          (rst),
      .update       (pc_update),
      .jump_en      (jump_en),
      .jump_address (jump_address),
      .pc           (pc)
   );

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc;
   assign instruction = instr_q;
   assign alu_en      = (state_q == ST_EXEC);
   assign dmem_req    = (state_q == ST_MEM);
   assign dmem_we     = dmem_we_q;
   assign rf_we       = rf_we_q;
   assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a table of instructions with
// hand-computed PC/strobe expectations, plus halt and reset-mid-MEM sequences.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic        reg_write_enable, mem_load, mem_store, jump_en;
   logic [31:0] jump_address;
   logic        alu_en, dmem_req, dmem_we, dmem_ready, rf_we;
   logic [31:0] pc;
   logic        halted;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .run              (run),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_rdata       (imem_rdata),
      .instruction      (instruction),
      .reg_write_enable (reg_write_enable),
      .mem_load         (mem_load),
      .mem_store        (mem_store),
      .jump_en          (jump_en),
      .jump_address     (jump_address),
      .alu_en           (alu_en),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_ready       (dmem_ready),
      .rf_we            (rf_we),
      .pc               (pc),
      .halted           (halted)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        rwe, ld, st, jmp;
      logic [31:0] jaddr;
      int          delay;
      logic        run_mid;
      logic [31:0] start_pc;
      logic [31:0] exp_pc;
      logic        exp_we;
      int          exp_mem;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered at a negedge while the DUT is in FETCH; leaves it in FETCH again.
   task automatic run_vec(input vec_t v, input int idx);
      int n;
      imem_rdata       = v.rdata;
      imem_ready       = 1'b1;
      reg_write_enable = v.rwe;
      mem_load         = v.ld;
      mem_store        = v.st;
      jump_en          = v.jmp;
      jump_address     = v.jaddr;
      chk($sformatf("v%0d fetch_req", idx), 32'(imem_req), 32'd1);
      chk($sformatf("v%0d fetch_addr", idx), imem_addr, v.start_pc);
      tick();
      imem_ready = 1'b0;
      run        = v.run_mid;
      dmem_ready = 1'b1;
      chk($sformatf("v%0d ir", idx), instruction, v.rdata);
      chk($sformatf("v%0d decode_quiet", idx), {29'd0, imem_req, alu_en, dmem_req}, 32'd0);
      tick();
      dmem_ready = 1'b0;
      chk($sformatf("v%0d alu_en", idx), 32'(alu_en), 32'd1);
      tick();
      n = 0;
      if (v.exp_mem > 0) begin
         while (dmem_req === 1'b1 && n < 20) begin
            n++;
            chk($sformatf("v%0d dmem_we", idx), 32'(dmem_we), 32'(v.exp_we));
            dmem_ready = (n > v.delay);
            tick();
         end
         dmem_ready = 1'b0;
         chk($sformatf("v%0d mem_cycles", idx), 32'(n), 32'(v.exp_mem));
      end else begin
         chk($sformatf("v%0d no_dmem", idx), 32'(dmem_req), 32'd0);
      end
      chk($sformatf("v%0d rf_we", idx), 32'(rf_we), 32'(v.rwe));
      chk($sformatf("v%0d wb_alu_off", idx), 32'(alu_en), 32'd0);
      tick();
      chk($sformatf("v%0d next_req", idx), 32'(imem_req), 32'(v.run_mid));
      chk($sformatf("v%0d pc", idx), pc, v.exp_pc);
      chk($sformatf("v%0d rf_we_off", idx), 32'(rf_we), 32'd0);
      if (!v.run_mid) begin
         run = 1'b1;
         tick();
      end
   endtask

   initial begin
      //            rdata         rwe   ld    st    jmp   jaddr          dly run   start          exp_pc         we    mem
      vecs[0] = '{32'h1111_0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         0, 1'b1, 32'h0,         32'h1,         1'b0, 0};
      vecs[1] = '{32'h1111_0002, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         0, 1'b1, 32'h1,         32'h2,         1'b0, 0};
      vecs[2] = '{32'h2222_0040, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,        0, 1'b0, 32'h2,         32'h40,        1'b0, 0};
      vecs[3] = '{32'h3333_0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         3, 1'b1, 32'h40,        32'h41,        1'b0, 4};
      vecs[4] = '{32'h3333_0002, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         0, 1'b1, 32'h41,        32'h42,        1'b0, 1};
      vecs[5] = '{32'h4444_0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1, 1'b1, 32'h42,        32'h43,        1'b1, 2};
      vecs[6] = '{32'h2222_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 1'b1, 32'h43,        32'hFFFF_FFFF, 1'b0, 0};
      vecs[7] = '{32'h1111_0003, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         0, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b0, 0};

      rst = 1'b1; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
      reg_write_enable = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
      jump_en = 1'b0; jump_address = '0; dmem_ready = 1'b0;
      tick();
      chk("rst pc", pc, 32'h0);
      chk("rst ir", instruction, 32'h0);
      chk("rst strobes", {26'd0, halted, imem_req, dmem_req, dmem_we, alu_en, rf_we}, 32'd0);
      rst = 1'b0;
      tick();
      tick();
      chk("idle no req", 32'(imem_req), 32'd0);
      run = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Halt word: no IR load, PC frozen, later ready pulses ignored.
      imem_rdata = 32'hFFFF_FFFF;
      imem_ready = 1'b1;
      chk("halt fetch_req", 32'(imem_req), 32'd1);
      tick();
      chk("halted", 32'(halted), 32'd1);
      chk("halt ir kept", instruction, 32'h1111_0003);
      for (int i = 0; i < 4; i++) begin
         imem_ready = i[0];
         dmem_ready = 1'b1;
         chk("halt quiet", {27'd0, imem_req, dmem_req, alu_en, rf_we, dmem_we}, 32'd0);
         chk("halt pc", pc, 32'h0);
         chk("halt sticky", 32'(halted), 32'd1);
         tick();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("halt cleared", 32'(halted), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // One sequential instruction, then reset in the middle of a load.
      vecs[0].run_mid = 1'b1;
      run_vec(vecs[0], 8);
      imem_rdata = 32'h3333_00AA;
      imem_ready = 1'b1;
      mem_load = 1'b1; mem_store = 1'b0; jump_en = 1'b0; reg_write_enable = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick();
      tick();
      chk("mid mem req", 32'(dmem_req), 32'd1);
      chk("mid mem pc", pc, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rst dmem_req drop", 32'(dmem_req), 32'd0);
      chk("rst pc reload", pc, 32'h0);
      chk("rst ir clear", instruction, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not end, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
